// File: rtl/qnigma_tcp_tx_seg_strm.sv
// qnigma_tcp_tx_seg_strm
//
// Splits queued TCP payload into MSS-sized segments and streams one segment at a time
// from the byte-wide payload RAM to the TX packet engine.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pend, seq, len  payload pending, first unsent sequence number, bytes queued
//   mss             maximum segment size (0 = unlimited)
//   send            packet request to the TX engine
//   seg_seq/seg_len sequence number and length latched at segment start
//   req             TX engine asks for payload (header done)
//   addr            payload RAM read address (RAM has 1-cycle read latency)
//   val/last        payload byte valid / final byte of segment
//   sent            TX engine finished the packet
//   abort           cancel the segment in flight
//   done/tmo        1-cycle pulses: segment sent / watchdog expired
//   idle            no segment in progress
module qnigma_tcp_tx_seg_strm #(
    parameter int unsigned      D     = 10,
    parameter int unsigned      TMO_W = 16,
    parameter logic [TMO_W-1:0] TMO   = TMO_W'(50000)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pend,
    input  logic [31:0]  seq,
    input  logic [15:0]  len,
    input  logic [15:0]  mss,
    output logic         send,
    output logic [31:0]  seg_seq,
    output logic [15:0]  seg_len,
    input  logic         req,
    output logic [D-1:0] addr,
    output logic         val,
    output logic         last,
    input  logic         sent,
    input  logic         abort,
    output logic         done,
    output logic         tmo,
    output logic         idle
);

    typedef enum logic [1:0] {StIdle, StSend, StStream, StDrain} state_e;

    // Watchdog fires on the TMO-th cycle spent in SEND or DRAIN.
    localparam logic [TMO_W-1:0] TmoLast = TMO - 1'b1;

    state_e           state_q, state_d;
    logic             send_q, send_d;
    logic [31:0]      seg_seq_q, seg_seq_d;
    logic [15:0]      seg_len_q, seg_len_d;
    logic [D-1:0]     addr_q, addr_d;
    logic             val_q, val_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic             idle_q, idle_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             wdog_hit;

    assign wdog_hit = ((state_q == StSend) || (state_q == StDrain)) && (wdog_q == TmoLast);

    always_comb begin
        state_d   = state_q;
        send_d    = send_q;
        seg_seq_d = seg_seq_q;
        seg_len_d = seg_len_q;
        addr_d    = addr_q;
        val_d     = val_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wdog_d    = '0;  // cleared unless the current state keeps counting
        done_d    = 1'b0;
        tmo_d     = 1'b0;

        if (abort) begin
            state_d = StIdle;
            send_d  = 1'b0;
            val_d   = 1'b0;
            last_d  = 1'b0;
            addr_d  = seq[D-1:0];
        end else if (wdog_hit) begin
            state_d = StIdle;
            send_d  = 1'b0;
            tmo_d   = 1'b1;
            addr_d  = seq[D-1:0];
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_d = seq[D-1:0];
                    if (pend && (len != '0)) begin
                        seg_seq_d = seq;
                        seg_len_d = ((mss != '0) && (mss < len)) ? mss : len;
                        send_d    = 1'b1;
                        state_d   = StSend;
                    end
                end
                StSend: begin
                    if (req) begin
                        send_d  = 1'b0;
                        val_d   = 1'b1;
                        last_d  = (seg_len_q == 16'd1);
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = 16'd1;
                        state_d = StStream;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                StStream: begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 16'd1;
                    last_d = ((cnt_q + 16'd1) == seg_len_q);
                    if (cnt_q == seg_len_q) begin
                        val_d  = 1'b0;
                        last_d = 1'b0;
                        if (sent) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StDrain;
                        end
                    end else if (sent) begin
                        // Engine finished before all bytes were streamed: drop without done.
                        val_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (sent) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        idle_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            send_q    <= 1'b0;
            seg_seq_q <= '0;
            seg_len_q <= '0;
            addr_q    <= '0;
            val_q     <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            idle_q    <= 1'b1;
            cnt_q     <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            send_q    <= send_d;
            seg_seq_q <= seg_seq_d;
            seg_len_q <= seg_len_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            last_q    <= last_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            idle_q    <= idle_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
        end
    end

    assign send    = send_q;
    assign seg_seq = seg_seq_q;
    assign seg_len = seg_len_q;
    assign addr    = addr_q;
    assign val     = val_q;
    assign last    = last_q;
    assign done    = done_q;
    assign tmo     = tmo_q;
    assign idle    = idle_q;

endmodule

// File: doc/qnigma_tcp_tx_seg_strm.md
Name: qnigma_tcp_tx_seg_strm

Overview:
MSS-aware successor to the TCP payload streamer. It sits between the TCP transmit-queue logic and the TX packet engine. Each transmission is one segment of at most mss bytes:
- requests a packet with a latched segment sequence number and length;
- reads exactly that many bytes sequentially from the byte-wide payload RAM, flagging the last byte;
- reports completion, abort or engine timeout to the queue logic, which advances seq for the next segment.

Parameters:
D, 10, payload RAM address width; addresses wrap modulo 2^D.
TMO_W, 16, width of the watchdog counter.
TMO, 16'd50000, clock cycles allowed in SEND or DRAIN before the watchdog fires; TMO must be at least 1.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
pend  in  1  payload queued for transmission (level)
seq  in  32  sequence number of first unsent byte; sampled only at segment start
len  in  16  bytes queued from seq; sampled only at segment start
mss  in  16  maximum segment size; 0 means no limit
send  out  1  request to TX engine to build a payload packet
seg_seq  out  32  latched sequence number of current segment
seg_len  out  16  latched payload length of current segment
req  in  1  TX engine requests payload (header done)
addr  out  D  payload RAM read address (1-cycle read latency)
val  out  1  payload byte valid; aligned with RAM data
last  out  1  final payload byte of segment; only with val
sent  in  1  TX engine finished the packet
abort  in  1  cancel current segment (e.g. retransmit/reset)
done  out  1  1-cycle pulse: segment fully streamed and sent
tmo  out  1  1-cycle pulse: watchdog expired
idle  out  1  no segment in progress

Behaviour:
- Reset: state IDLE; send=0, val=0, last=0, done=0, tmo=0, idle=1, addr=0, seg_seq=0, seg_len=0, byte counter=0, watchdog=0.
- States: IDLE, SEND, STREAM, DRAIN.
- IDLE:
  - idle=1; addr tracks seq[D-1:0] every cycle.
  - If pend=1 and len!=0: seg_seq<=seq; seg_len<=(mss!=0 && mss<len) ? mss : len; send<=1; idle<=0; watchdog cleared; go to SEND.
  - pend=1 with len=0 is ignored.
- SEND:
  - Hold send=1 until req.
  - On req: send<=0, val<=1, last<=(seg_len==1), addr<=addr+1, counter<=1; go to STREAM.
- STREAM:
  - val stays high for exactly seg_len consecutive cycles, starting the cycle after req.
  - Each cycle: addr<=addr+1, counter<=counter+1.
  - last<=1 in the cycle where counter+1==seg_len, so last coincides with the final val cycle.
  - When counter==seg_len: val<=0, last<=0; go to DRAIN, or straight to IDLE with done pulse if sent is already 1.
  - addr wraps from 2^D-1 to 0 without a gap.
  - req is ignored once in STREAM.
- DRAIN: on sent, done<=1 for one cycle; go to IDLE.
- sent while still in STREAM (counter<seg_len) is an engine protocol error: val<=0, last<=0; go to IDLE; no done pulse.
- Watchdog:
  - Counts cycles in SEND and DRAIN; cleared on every state change.
  - On reaching TMO: tmo<=1 for one cycle, send<=0; go to IDLE; no done pulse.
  - Never runs in STREAM.
- abort:
  - Highest priority in any state, including the same cycle as req, sent or timeout expiry.
  - Next cycle: state IDLE, send=0, val=0, last=0, idle=1, no done or tmo pulse.
- Priority: rst > abort > tmo > sent > req.
- seq, len and mss changes after segment start do not affect the segment in flight.
- Only one segment is in flight at a time. A new segment may start the cycle after done, i.e. the cycle after IDLE is re-entered.
- seg_seq and seg_len hold their values until the next segment start.

Test Plan:
1. seq=32'h0000_03FE, len=5, mss=0, pend=1; req 3 cycles after send -> seg_len=5; val high 5 cycles; addr sequence 3FE,3FF,000,001,002 (wrap at D=10); last only on the 5th val; done one cycle after sent.
2. len=3000, mss=1460 -> seg_len=1460 with exactly 1460 val cycles. Queue logic advances seq by 1460 after done -> second segment 1460, third 80, each with a single last.
3. len=1, req -> val and last both high for one cycle only; then DRAIN; sent -> done.
4. Hold req low for TMO cycles in SEND -> tmo pulse, send drops, idle=1, no done. Repeat with sent withheld in DRAIN -> same response.
5. abort asserted mid-STREAM (byte 7 of 20) and asserted together with req -> next cycle val=0, last=0, send=0, idle=1, no done. A new pend then restarts from the current seq.
6. sent asserted at byte 4 of 10 -> val drops next cycle, IDLE, no done. rst asserted mid-STREAM -> all outputs return to reset values next cycle.
